// File: rtl/bus_matrix_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bus_matrix_req_ctrl
// Purpose  : Master-side request controller for one bus matrix master port.
//            Accepts a burst command, requests the slave from the per-slave
//            arbiter, holds the grant for the whole burst, sequences the
//            beats and then releases the request so the arbiter can
//            re-arbitrate on the following cycle.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            cmd_valid_i/cmd_ready_o, cmd_addr_i, cmd_len_i
//                              - command handshake, start address, beats-1
//            req_o, hold_o     - request / hold-grant toward the arbiter
//            gnt_i             - this master's bit of the registered grant
//            bus_valid_o, bus_addr_o, bus_last_o, bus_ready_i
//                              - beat channel toward the slave
//            done_o, err_o     - completion / grant-timeout pulses
// Revision : 1.0 - initial release
// ============================================================================
module bus_matrix_req_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BURST_W     = 4,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [ADDR_W-1:0]  cmd_addr_i,
    input  logic [BURST_W-1:0] cmd_len_i,
    output logic               req_o,
    output logic               hold_o,
    input  logic               gnt_i,
    output logic               bus_valid_o,
    output logic [ADDR_W-1:0]  bus_addr_o,
    output logic               bus_last_o,
    input  logic               bus_ready_i,
    output logic               done_o,
    output logic               err_o
);

    // Wait counter needs at least one bit even when the timeout is disabled.
    localparam int                  c_WAIT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit                  c_TO_EN     = (TIMEOUT_CYC != 0);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = '1;
    localparam logic [ADDR_W-1:0]   c_STRIDE    = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_REQ   = 2'd1,
        c_BURST = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [BURST_W-1:0]  r_len;
    logic [BURST_W-1:0]  r_beat;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_done;
    logic                r_err;

    logic w_active;
    logic w_bus_valid;
    logic w_last;
    logic w_accept;
    logic w_last_acc;
    logic w_timeout;

    assign w_active    = (r_state == c_REQ) || (r_state == c_BURST);
    // A dropped grant mid-burst simply pauses the beats.
    assign w_bus_valid = (r_state == c_BURST) && gnt_i;
    assign w_last      = w_bus_valid && (r_beat == r_len);
    assign w_accept    = w_bus_valid && bus_ready_i;
    assign w_last_acc  = w_accept && w_last;
    assign w_timeout   = c_TO_EN && (r_state == c_REQ) && !gnt_i && (r_wait == c_WAIT_LAST);

    // Request and hold drop combinationally in the last-beat cycle so the
    // arbiter re-arbitrates at that very edge. Hold is asserted from the first
    // granted REQ cycle so no other master can be granted before BURST.
    assign cmd_ready_o = (r_state == c_IDLE);
    assign req_o       = w_active && !w_last_acc;
    assign hold_o      = gnt_i && w_active && !w_last_acc;
    assign bus_valid_o = w_bus_valid;
    assign bus_addr_o  = r_addr;
    assign bus_last_o  = w_last;
    assign done_o      = r_done;
    assign err_o       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_wait  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid_i) begin
                        r_addr  <= cmd_addr_i;
                        r_len   <= cmd_len_i;
                        r_beat  <= '0;
                        r_wait  <= '0;
                        r_state <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (gnt_i) begin
                        r_state <= c_BURST;
                    end else if (w_timeout) begin
                        r_state <= c_IDLE;
                        r_err   <= 1'b1;
                    end else if (r_wait != c_WAIT_MAX) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                c_BURST: begin
                    if (w_accept) begin
                        r_addr <= r_addr + c_STRIDE;
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_matrix_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bus_matrix_req_ctrl
// Purpose  : Self-checking bench for bus_matrix_req_ctrl. A registered
//            arbiter model answers req_o one cycle later, a scoreboard holds
//            the expected beat sequence, and a second instance with an
//            8-cycle grant timeout covers the abort path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_matrix_req_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (timeout disabled)
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        req, hold, gnt;
    logic        bus_valid, bus_last, bus_ready;
    logic [31:0] bus_addr;
    logic        done, err;

    // timeout instance
    logic        t_cmd_valid, t_cmd_ready;
    logic [31:0] t_cmd_addr;
    logic [3:0]  t_cmd_len;
    logic        t_req, t_hold, t_gnt;
    logic        t_bus_valid, t_bus_last, t_bus_ready;
    logic [31:0] t_bus_addr;
    logic        t_done, t_err;

    int    checks   = 0;
    int    failures = 0;
    int    done_cnt = 0;
    int    err_cnt  = 0;
    beat_t exp_q[$];

    bus_matrix_req_ctrl #(.ADDR_W(32), .DATA_W(32), .BURST_W(4), .TIMEOUT_CYC(0)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .req_o(req), .hold_o(hold), .gnt_i(gnt),
        .bus_valid_o(bus_valid), .bus_addr_o(bus_addr), .bus_last_o(bus_last),
        .bus_ready_i(bus_ready), .done_o(done), .err_o(err)
    );

    bus_matrix_req_ctrl #(.ADDR_W(32), .DATA_W(32), .BURST_W(4), .TIMEOUT_CYC(8)) dut_to (
        .clk(clk), .rst(rst),
        .cmd_valid_i(t_cmd_valid), .cmd_ready_o(t_cmd_ready),
        .cmd_addr_i(t_cmd_addr), .cmd_len_i(t_cmd_len),
        .req_o(t_req), .hold_o(t_hold), .gnt_i(t_gnt),
        .bus_valid_o(t_bus_valid), .bus_addr_o(t_bus_addr), .bus_last_o(t_bus_last),
        .bus_ready_i(t_bus_ready), .done_o(t_done), .err_o(t_err)
    );

    // Arbiter model: registered grant follows req one cycle later, optionally
    // withheld for block_left requesting cycles.
    logic req_seen = 1'b0;
    int   block_left = 0;
    always @(negedge clk) req_seen = req;
    always @(posedge clk) begin
        #1;
        if (req_seen && block_left > 0) begin
            block_left = block_left - 1;
            gnt = 1'b0;
        end else begin
            gnt = req_seen;
        end
    end

    // Slave ready: 0 = always ready, 1 = toggles every cycle.
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) bus_ready = 1'b1;
        else                 bus_ready = ~bus_ready;
    end

    // Scoreboard monitor for the main instance.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic        prev_last  = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (err)  err_cnt++;
            if (prev_stall && bus_valid) begin
                checks++;
                if (bus_addr !== prev_addr || bus_last !== prev_last) begin
                    failures++;
                    $display("FAIL stall_stable addr=%h last=%b required addr=%h last=%b",
                             bus_addr, bus_last, prev_addr, prev_last);
                end
            end
            if (bus_valid && bus_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected addr=%h required no beat", bus_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_addr !== e.addr || bus_last !== e.last) begin
                        failures++;
                        $display("FAIL beat addr=%h last=%b required addr=%h last=%b",
                                 bus_addr, bus_last, e.addr, e.last);
                    end
                end
            end
            prev_stall = bus_valid && !bus_ready;
            prev_addr  = bus_addr;
            prev_last  = bus_last;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [31:0] addr, input logic [3:0] len);
        beat_t b;
        for (int i = 0; i <= int'(len); i++) begin
            b.addr = addr + 32'(i * 4);
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
    endtask

    // Presents a command in cycle T; returns in cycle T+1 with cmd_valid low.
    task automatic send_cmd(input logic [31:0] addr, input logic [3:0] len);
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        push_beats(addr, len);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_idle got=%b required=1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; cyc counts from T+1 = 1.
    task automatic wait_done(input int bound, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (done) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({cmd_ready, req, hold, bus_valid, bus_last, done, err} !== 7'b1000000 || bus_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_values got=%b addr=%h required=1000000 addr=0",
                     {cmd_ready, req, hold, bus_valid, bus_last, done, err}, bus_addr);
        end
        checks++;
        if ({t_cmd_ready, t_req, t_hold, t_bus_valid, t_bus_last, t_done, t_err} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_values_to got=%b required=1000000",
                     {t_cmd_ready, t_req, t_hold, t_bus_valid, t_bus_last, t_done, t_err});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_beat;
        send_cmd(32'h100, 4'd0);
        @(negedge clk);  // T+1
        checks++;
        if ({req, hold, cmd_ready, bus_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL single_t1 req/hold/rdy/vld=%b required=1000", {req, hold, cmd_ready, bus_valid});
        end
        tick();
        @(negedge clk);  // T+2
        checks++;
        if ({req, hold, bus_valid} !== 3'b110) begin
            failures++;
            $display("FAIL single_t2 req/hold/vld=%b required=110", {req, hold, bus_valid});
        end
        tick();
        @(negedge clk);  // T+3
        checks++;
        if ({req, hold, bus_valid, bus_last} !== 4'b0011 || bus_addr !== 32'h100) begin
            failures++;
            $display("FAIL single_t3 req/hold/vld/last=%b addr=%h required=0011 addr=00000100",
                     {req, hold, bus_valid, bus_last}, bus_addr);
        end
        tick();
        @(negedge clk);  // T+4
        checks++;
        if ({done, cmd_ready, hold, req} !== 4'b1100) begin
            failures++;
            $display("FAIL single_t4 done/rdy/hold/req=%b required=1100", {done, cmd_ready, hold, req});
        end
        tick();
        @(negedge clk);  // T+5
        checks++;
        if (done !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_end done=%b pending=%0d required done=0 pending=0", done, exp_q.size());
        end
        tick();
    endtask

    task automatic test_stall_burst;
        int acc;
        bit fin;
        bit exp_valid, exp_last, exp_hold, exp_req;
        acc = 0;
        fin = 1'b0;
        ready_mode = 1;
        tick();
        send_cmd(32'h40, 4'd3);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (fin) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_done got=%b required=1", done);
                end
                break;
            end
            exp_valid = (i >= 3);
            exp_last  = exp_valid && (acc == 3);
            exp_req   = !(exp_last && bus_ready);
            exp_hold  = (i >= 2) && exp_req;
            checks++;
            if ({bus_valid, bus_last, hold, req} !== {exp_valid, exp_last, exp_hold, exp_req}) begin
                failures++;
                $display("FAIL stall_cycle%0d vld/last/hold/req=%b required=%b", i,
                         {bus_valid, bus_last, hold, req}, {exp_valid, exp_last, exp_hold, exp_req});
            end
            if (exp_valid && bus_ready) begin
                acc++;
                if (acc == 4) fin = 1'b1;
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || !fin) begin
            failures++;
            $display("FAIL stall_complete pending=%0d finished=%b required pending=0 finished=1", exp_q.size(), fin);
        end
        ready_mode = 0;
        tick();
        tick();
    endtask

    task automatic test_contention;
        bit ok;
        int cyc;
        int err0;
        err0 = err_cnt;
        ok   = 1'b0;
        cyc  = 0;
        block_left = 5;
        tick();
        send_cmd(32'h300, 4'd1);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
            if (i <= 6) begin
                checks++;
                if ({req, bus_valid, err} !== 3'b100) begin
                    failures++;
                    $display("FAIL contend_wait%0d req/vld/err=%b required=100", i, {req, bus_valid, err});
                end
            end
            tick();
        end
        checks++;
        if (!ok || cyc != 10) begin
            failures++;
            $display("FAIL contend_done ok=%b cycle=%0d required ok=1 cycle=10", ok, cyc);
        end
        tick();
        checks++;
        if (err_cnt != err0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL contend_clean errs=%0d pending=%0d required errs=%0d pending=0",
                     err_cnt, exp_q.size(), err0);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        bit ok;
        int cyc;
        int gap;
        gap = 0;
        send_cmd(32'h500, 4'd2);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h600;
        cmd_len   = 4'd2;
        push_beats(32'h600, 4'd2);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                gap = i;
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_done_with_ready done=%b required=1", done);
                end
                break;
            end
            tick();
        end
        checks++;
        if (gap != 6) begin
            failures++;
            $display("FAIL b2b_gap cycles=%0d required=6", gap);
        end
        tick();
        cmd_valid = 1'b0;
        wait_done(30, ok, cyc);
        checks++;
        if (!ok || cyc != 6 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_second ok=%b cycle=%0d pending=%0d required ok=1 cycle=6 pending=0",
                     ok, cyc, exp_q.size());
        end
        tick();
    endtask

    task automatic test_wrap_max;
        bit ok;
        int cyc;
        send_cmd(32'hFFFF_FFF8, 4'd15);
        wait_done(60, ok, cyc);
        checks++;
        if (!ok || cyc != 19 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_done ok=%b cycle=%0d pending=%0d required ok=1 cycle=19 pending=0",
                     ok, cyc, exp_q.size());
        end
        tick();
    endtask

    task automatic test_timeout;
        t_cmd_valid = 1'b1;
        t_cmd_addr  = 32'h700;
        t_cmd_len   = 4'd0;
        tick();
        t_cmd_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if ({t_req, t_err, t_cmd_ready, t_bus_valid} !== 4'b1000) begin
                failures++;
                $display("FAIL timeout_wait%0d req/err/rdy/vld=%b required=1000", i,
                         {t_req, t_err, t_cmd_ready, t_bus_valid});
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({t_req, t_err, t_cmd_ready, t_bus_valid} !== 4'b0110) begin
            failures++;
            $display("FAIL timeout_abort req/err/rdy/vld=%b required=0110", {t_req, t_err, t_cmd_ready, t_bus_valid});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({t_req, t_err, t_cmd_ready, t_bus_valid} !== 4'b0010) begin
            failures++;
            $display("FAIL timeout_after req/err/rdy/vld=%b required=0010", {t_req, t_err, t_cmd_ready, t_bus_valid});
        end
        tick();

        // Grant arriving in the final allowed REQ cycle must win over the timeout.
        t_cmd_valid = 1'b1;
        t_cmd_addr  = 32'h800;
        tick();
        t_cmd_valid = 1'b0;
        repeat (7) tick();
        t_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if ({t_req, t_hold, t_err} !== 3'b110) begin
            failures++;
            $display("FAIL timeout_late_gnt req/hold/err=%b required=110", {t_req, t_hold, t_err});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({t_bus_valid, t_bus_last, t_err} !== 3'b110 || t_bus_addr !== 32'h800) begin
            failures++;
            $display("FAIL timeout_late_beat vld/last/err=%b addr=%h required=110 addr=00000800",
                     {t_bus_valid, t_bus_last, t_err}, t_bus_addr);
        end
        tick();
        t_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if ({t_done, t_err} !== 2'b10) begin
            failures++;
            $display("FAIL timeout_late_done done/err=%b required=10", {t_done, t_err});
        end
        tick();
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        int cyc;
        send_cmd(32'h200, 4'd3);
        tick();
        tick();
        tick();          // T+4: second beat on the bus
        rst = 1'b1;
        tick();          // T+5
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, req, hold, bus_valid, bus_last, done, err} !== 7'b1000000 || bus_addr !== 32'h0) begin
            failures++;
            $display("FAIL midreset_values got=%b addr=%h required=1000000 addr=0",
                     {cmd_ready, req, hold, bus_valid, bus_last, done, err}, bus_addr);
        end
        exp_q.delete();
        tick();
        tick();
        send_cmd(32'h900, 4'd1);
        wait_done(30, ok, cyc);
        checks++;
        if (!ok || cyc != 5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_recover ok=%b cycle=%0d pending=%0d required ok=1 cycle=5 pending=0",
                     ok, cyc, exp_q.size());
        end
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        gnt         = 1'b0;
        bus_ready   = 1'b1;
        t_cmd_valid = 1'b0;
        t_cmd_addr  = '0;
        t_cmd_len   = '0;
        t_gnt       = 1'b0;
        t_bus_ready = 1'b1;
        tick();
        test_reset();
        test_single_beat();
        test_stall_burst();
        test_contention();
        test_back_to_back();
        test_wrap_max();
        test_timeout();
        test_reset_mid_burst();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
